// File: rtl/pipo_rr_ctrl_if.sv
// Bundle of requester, consumer and status signals around the shared PIPO register.
// master drives requests/ack; slave (the controller) drives the register view.
interface pipo_rr_ctrl_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
) ();
  localparam int unsigned SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] d;
  logic              ack;
  logic [W-1:0]      q;
  logic              v;
  logic [NREQ-1:0]   gnt;
  logic [SRC_W-1:0]  src;
  logic [7:0]        cnt;
  logic              err;

  modport master (output req, d, ack, input q, v, gnt, src, cnt, err);
  modport slave  (input req, d, ack, output q, v, gnt, src, cnt, err);
endinterface

// File: rtl/pipo_rr_ctrl.sv
// Round-robin loader for a single shared W-bit holding register with valid/ack hand-off.
// Define PIPO_ARB_TIMEOUT_EN to abort a presentation that waits TIMEOUT cycles for ack.
module pipo_rr_ctrl #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           clr,
  pipo_rr_ctrl_if.slave  bus
);
  localparam int unsigned SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, VALID} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     q_q, q_d;
  logic             v_q, v_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [SRC_W-1:0] win_c;
  logic             found_c;
  int unsigned      idx_c;

`ifdef PIPO_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // First requester after the last winner, wrapping around.
  always_comb begin
    win_c   = '0;
    found_c = 1'b0;
    idx_c   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx_c = (32'(ptr_q) + k) % NREQ;
      if (!found_c && bus.req[idx_c]) begin
        found_c = 1'b1;
        win_c   = SRC_W'(idx_c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    v_d     = v_q;
    gnt_d   = '0;
    src_d   = src_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef PIPO_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_c) begin
          q_d     = bus.d[32'(win_c) * W +: W];
          src_d   = win_c;
          gnt_d   = NREQ'(1) << win_c;
          v_d     = 1'b1;
          ptr_d   = win_c;
          cnt_d   = cnt_q + 8'd1;
          state_d = VALID;
`ifdef PIPO_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      VALID: begin
        if (bus.ack) begin
          v_d     = 1'b0;
          state_d = IDLE;
        end
`ifdef PIPO_ARB_TIMEOUT_EN
        // Expiry on the TIMEOUT-th unacknowledged cycle; q is kept.
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          v_d     = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      q_q     <= '0;
      v_q     <= 1'b0;
      gnt_q   <= '0;
      src_q   <= '0;
      ptr_q   <= SRC_W'(NREQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef PIPO_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      v_q     <= v_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef PIPO_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign bus.q   = q_q;
  assign bus.v   = v_q;
  assign bus.gnt = gnt_q;
  assign bus.src = src_q;
  assign bus.cnt = cnt_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_pipo_rr_ctrl.sv
// Scoreboard bench for pipo_rr_ctrl: stimulus queues expected loads, a monitor checks each grant.
module tb_pipo_rr_ctrl;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;
`ifdef PIPO_ARB_TIMEOUT_EN
  localparam int unsigned TO    = 4;
  localparam int unsigned STALL = 3;
`else
  localparam int unsigned TO    = 15;
  localparam int unsigned STALL = 10;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] src;
    logic [3:0] q;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pipo_rr_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

  pipo_rr_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] s, input logic [3:0] qv, input logic [7:0] c);
    exp_t e;
    e.gnt = g; e.src = s; e.q = qv; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every grant pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!clr && bus.gnt !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 32'(bus.gnt), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("gnt", 32'(bus.gnt), 32'(e.gnt));
        check("src", 32'(bus.src), 32'(e.src));
        check("q",   32'(bus.q),   32'(e.q));
        check("cnt", 32'(bus.cnt), 32'(e.cnt));
        check("v_with_gnt", 32'(bus.v), 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with everything requesting.
    clr = 1'b1; bus.req = 4'b1111; bus.d = 16'hFFFF; bus.ack = 1'b0;
    tick(2);
    check("rst_q",   32'(bus.q),   32'h0);
    check("rst_v",   32'(bus.v),   32'h0);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_src", 32'(bus.src), 32'h0);
    check("rst_cnt", 32'(bus.cnt), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    clr = 1'b0; bus.req = '0; bus.d = '0;
    tick(1);

    // Single load from requester 1.
    bus.req = 4'b0010; bus.d = 16'h0030;
    push(4'b0010, 2'd1, 4'h3, 8'd1);
    tick(1);
    bus.req = '0; bus.ack = 1'b1;
    tick(1);
    check("single_v_after_ack", 32'(bus.v),   32'h0);
    check("single_gnt_low",     32'(bus.gnt), 32'h0);
    bus.ack = 1'b0;

    // Fairness from a fresh pointer: all requesting, ack held high.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    bus.req = 4'b1111; bus.d = 16'hDCBA; bus.ack = 1'b1;
    push(4'b0001, 2'd0, 4'hA, 8'd1);
    push(4'b0010, 2'd1, 4'hB, 8'd2);
    push(4'b0100, 2'd2, 4'hC, 8'd3);
    push(4'b1000, 2'd3, 4'hD, 8'd4);
    push(4'b0001, 2'd0, 4'hA, 8'd5);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i % 2 == 0) begin
        check("fair_idle_gnt", 32'(bus.gnt), 32'h0);
        check("fair_idle_v",   32'(bus.v),   32'h0);
      end
    end
    bus.req = '0; bus.ack = 1'b0;
    tick(1);

    // Stall: requests and data change while q is presented without ack.
    bus.req = 4'b0100; bus.d = 16'h0500;
    push(4'b0100, 2'd2, 4'h5, 8'd6);
    tick(1);
    bus.req = 4'b1011; bus.d = 16'hFFFF;
    for (int i = 0; i < int'(STALL); i++) begin
      tick(1);
      check("stall_q",   32'(bus.q),   32'h5);
      check("stall_src", 32'(bus.src), 32'h2);
      check("stall_v",   32'(bus.v),   32'h1);
      check("stall_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.req = '0; bus.ack = 1'b1;
    tick(1);
    check("stall_release_v", 32'(bus.v), 32'h0);
    bus.ack = 1'b0;

    // Reset during the second VALID cycle, then restart from requester 0.
    bus.req = 4'b1000; bus.d = 16'h7000;
    push(4'b1000, 2'd3, 4'h7, 8'd7);
    tick(1);
    bus.req = '0;
    tick(1);
    clr = 1'b1;
    tick(1);
    check("midrst_v",   32'(bus.v),   32'h0);
    check("midrst_q",   32'(bus.q),   32'h0);
    check("midrst_cnt", 32'(bus.cnt), 32'h0);
    clr = 1'b0; bus.req = 4'b1111; bus.d = 16'hDCBA;
    push(4'b0001, 2'd0, 4'hA, 8'd1);
    tick(1);
    bus.req = '0; bus.ack = 1'b1;
    tick(1);
    check("midrst_done_v", 32'(bus.v), 32'h0);
    bus.ack = 1'b0;

    // Long wait without ack: abort with timeout, otherwise hold.
    bus.req = 4'b0010; bus.d = 16'h0090;
    push(4'b0010, 2'd1, 4'h9, 8'd2);
    tick(1);
    bus.req = '0;
`ifdef PIPO_ARB_TIMEOUT_EN
    for (int i = 2; i <= int'(TO); i++) begin
      tick(1);
      check("to_v_hold", 32'(bus.v),   32'h1);
      check("to_err_lo", 32'(bus.err), 32'h0);
    end
    tick(1);
    check("to_v_drop", 32'(bus.v),   32'h0);
    check("to_err_hi", 32'(bus.err), 32'h1);
    check("to_q_kept", 32'(bus.q),   32'h9);
    tick(1);
    check("to_err_pulse", 32'(bus.err), 32'h0);
    check("to_v_idle",    32'(bus.v),   32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("hold_v",   32'(bus.v),   32'h1);
      check("hold_err", 32'(bus.err), 32'h0);
      check("hold_q",   32'(bus.q),   32'h9);
    end
    bus.ack = 1'b1;
    tick(1);
    check("hold_release_v", 32'(bus.v), 32'h0);
    bus.ack = 1'b0;
`endif

    // Every queued load must have been observed.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipo_rr_ctrl.md
# pipo_rr_ctrl

Round-robin controller that shares a single W-bit parallel-in/parallel-out holding register between NREQ requesters. Each cycle in which the register is free, it selects one requesting source, loads that source's parallel word into the register, and presents it downstream with a valid flag until the consumer acknowledges. It sits between several producers and the single parallel register/consumer path, and sequences every load into that register.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, data width of each requester word and of q
- TIMEOUT, 15, cycles v may stay high without ack before abort (only with PIPO_ARB_TIMEOUT_EN)
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester load request, level
- d  in  NREQ*W  packed request words; slice i = d[i*W +: W]
- ack  in  1  consumer accepts current q
- q  out  W  holding register contents
- v  out  1  q valid
- gnt  out  NREQ  one-hot, one-cycle pulse identifying the loaded requester
- src  out  log2(NREQ) (min 1)  index of requester owning q
- cnt  out  8  number of completed loads, wraps 255 -> 0
- err  out  1  one-cycle timeout abort pulse

## Operation
- Reset (clr=1 at edge): q=0, v=0, gnt=0, src=0, cnt=0, err=0, state=IDLE, ptr=NREQ-1 (requester 0 has first priority). clr overrides all other inputs.
- States: IDLE (register free), VALID (q presented).
- IDLE, req==0: remain; gnt=0.
- IDLE, req!=0: winner = first set bit searching ptr+1, ptr+2, … mod NREQ. At the edge: q<=d slice winner, src<=winner, gnt<=onehot(winner), v<=1, ptr<=winner, cnt<=cnt+1, -> VALID.
- VALID: q, src frozen; req ignored; gnt=0 after its single pulse cycle.
- VALID, ack=1: v<=0, -> IDLE. No same-edge reload; the next load is sampled in the following IDLE cycle.
- ack while IDLE: ignored.
- Requester contract: hold req and its d slice until gnt seen; drop req in the cycle after gnt if no further word pending. A requester still holding req is eligible again, but only after all other requesting sources (round-robin fairness).
- Round-robin pointer advances only on a load; abort (timeout) does not move it further.

## Timing
- Load latency: req sampled in IDLE at edge k -> q, v, gnt, src valid in cycle k+1.
- Minimum load-to-load period: 2 cycles (VALID with ack in first cycle, then IDLE).
- gnt high exactly one cycle, coincident with the first cycle of v.
- ack in the first VALID cycle is legal: v low in the next cycle.
- clr in VALID: all outputs reset at that edge; pending transfer discarded, cnt=0.
- cnt increments on load, not on ack; wraps silently.

## Configuration
- PIPO_ARB_TIMEOUT_EN defined: a counter clears on entry to VALID and increments each VALID cycle without ack. When it reaches TIMEOUT with ack still low, at that edge v<=0, err<=1 for one cycle, -> IDLE; q keeps its last value. ack in the same cycle as expiry wins (normal completion, no err). Counter cleared by clr.
- Not defined: no counter; v holds indefinitely until ack; err tied 0; TIMEOUT unused.

## Test plan
- Reset: clr=1 with req=4'b1111, d all ones -> after edge q=0, v=0, gnt=0, src=0, cnt=0; no grant while clr high.
- Single load: req=4'b0010, slice1=4'b0011 -> next cycle q=4'b0011, v=1, gnt=4'b0010, src=1, cnt=1; ack=1 -> v=0 next cycle.
- Fairness: req=4'b1111 held, ack each VALID cycle -> gnt sequence 0001, 0010, 0100, 1000, 0001 at 2-cycle spacing; cnt increments by 1 per load.
- Stall: ack=0 for 10 cycles in VALID, req changes and d changes -> q, src, v unchanged; no gnt.
- Reset mid-transfer: clr=1 in the second VALID cycle -> v=0, q=0, cnt=0 next cycle; next load with req=4'b1111 grants requester 0.
- Timeout (macro defined, TIMEOUT=4): load, ack=0 -> v falls after 4 VALID cycles, err one-cycle pulse, q retained; without the macro, v remains high and err stays 0.
